// File: rtl/laser_beacon_tracker.sv
// Turret beacon tracker: synchronised x4 quadrature position counter zeroed by the index pulse,
// plus a FIFO of {start, end, revolution} beacon records. Optional input glitch filter: LASER_FILTER_EN.
module laser_beacon_tracker #(
   parameter int POS_W             = 16,
   parameter int REV_W             = 8,
   parameter int DEPTH             = 8,
   parameter bit SIGNAL_ACTIVE_LOW = 1'b1,
   parameter int FILTER_LEN        = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     Laser_signal,
   input  logic                     Laser_sync,
   input  logic                     Laser_cod_A,
   input  logic                     Laser_cod_B,
   output logic [POS_W-1:0]         position,
   output logic [REV_W-1:0]         rev_count,
   output logic [POS_W-1:0]         rev_period,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [POS_W-1:0]         rd_start,
   output logic [POS_W-1:0]         rd_end,
   output logic [REV_W-1:0]         rd_rev,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);

   // Pin vector order: [3] signal, [2] sync, [1] encoder A, [0] encoder B.
   localparam logic [3:0] PIN_IDLE = {SIGNAL_ACTIVE_LOW, 3'b000};

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FILTER_LEN < 1) begin : g_bad_params
      $error("laser_beacon_tracker: DEPTH must be a power of two >= 2 and FILTER_LEN >= 1");
   end

   typedef enum logic {IDLE, ACTIVE} state_t;

   typedef struct packed {
      logic [POS_W-1:0] start_pos;
      logic [POS_W-1:0] end_pos;
      logic [REV_W-1:0] rev;
   } rec_t;

   logic [3:0] pins, sync1, sync2, cur, prv;

   assign pins = {Laser_signal, Laser_sync, Laser_cod_A, Laser_cod_B};

   // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= PIN_IDLE;
         sync2 <= PIN_IDLE;
      end else begin
         sync1 <= pins;
         sync2 <= sync1;
      end
   end

`ifdef LASER_FILTER_EN
   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [3:0]    flt;
   logic [CW-1:0] flt_cnt [4];

   // A pin's filtered level follows only after FILTER_LEN consecutive samples at the new level.
   always_ff @(posedge clk) begin
      if (reset) begin
         flt <= PIN_IDLE;
         for (int i = 0; i < 4; i++) flt_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] != flt[i]) begin
               if (flt_cnt[i] == CW'(FILTER_LEN - 1)) begin
                  flt[i]     <= sync2[i];
                  flt_cnt[i] <= '0;
               end else begin
                  flt_cnt[i] <= flt_cnt[i] + 1'b1;
               end
            end else begin
               flt_cnt[i] <= '0;
            end
         end
      end
   end

   assign cur = flt;
`else
   assign cur = sync2;
`endif

   always_ff @(posedge clk) begin
      if (reset) prv <= PIN_IDLE;
      else       prv <= cur;
   end

   logic beacon_on, beacon_was, start_edge, end_edge, sync_rise, step_en, step_up;

   assign beacon_on  = cur[3] ^ SIGNAL_ACTIVE_LOW;
   assign beacon_was = prv[3] ^ SIGNAL_ACTIVE_LOW;
   assign start_edge = beacon_on & ~beacon_was;
   assign end_edge   = ~beacon_on & beacon_was;
   assign sync_rise  = cur[2] & ~prv[2];
   assign step_en    = cur[1] ^ prv[1] ^ cur[0] ^ prv[0];
   assign step_up    = cur[1] ^ prv[0];

   // The index pulse wins over a coincident encoder step; that step is lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         position   <= '0;
         rev_count  <= '0;
         rev_period <= '0;
      end else if (sync_rise) begin
         rev_period <= position;
         position   <= '0;
         rev_count  <= rev_count + 1'b1;
      end else if (step_en) begin
         position <= step_up ? position + 1'b1 : position - 1'b1;
      end
   end

   state_t           state, state_nxt;
   logic             push, latch_start;
   logic [POS_W-1:0] start_pos;
   logic [REV_W-1:0] start_rev;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: defaults first so every path assigns every output and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      push        = 1'b0;
      latch_start = 1'b0;
      case (state)
         IDLE: begin
            if (start_edge) begin
               latch_start = 1'b1;
               state_nxt   = ACTIVE;
            end
         end
         ACTIVE: begin
            if (sync_rise) begin
               state_nxt = IDLE;
            end else if (end_edge) begin
               push      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A start coinciding with the index pulse belongs to the new revolution.
   always_ff @(posedge clk) begin
      if (reset) begin
         start_pos <= '0;
         start_rev <= '0;
      end else if (latch_start) begin
         start_pos <= sync_rise ? '0 : position;
         start_rev <= sync_rise ? rev_count + 1'b1 : rev_count;
      end
   end

   rec_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level;
   logic          full, pop, accept;

   assign full   = (level == (AW + 1)'(DEPTH));
   assign pop    = rd_valid & rd_ready;
   assign accept = push & (~full | pop);

   // NOTE: storage is left unreset; pointers and level alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= '{start_pos: start_pos, end_pos: position, rev: start_rev};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (push & full & ~pop) overflow <= 1'b1;
      end
   end

   assign rd_valid   = (level != '0);
   assign fifo_level = level;
   assign rd_start   = mem[rd_ptr].start_pos;
   assign rd_end     = mem[rd_ptr].end_pos;
   assign rd_rev     = mem[rd_ptr].rev;

endmodule

// File: tb/tb_laser_beacon_tracker.sv
// Bench for laser_beacon_tracker: directed test-plan scenarios plus randomized pin activity,
// all checked every cycle against a behavioural model of pins, revolutions and the record queue.
module tb_laser_beacon_tracker;

   localparam int POS_W = 16;
   localparam int REV_W = 8;
   localparam int DEPTH = 8;
   localparam bit SAL   = 1'b1;
   localparam logic [3:0] IDLE_PINS = {SAL, 3'b000};

   logic             clk = 1'b0;
   logic             reset;
   logic             Laser_signal, Laser_sync, Laser_cod_A, Laser_cod_B;
   logic [POS_W-1:0] position, rev_period, rd_start, rd_end;
   logic [REV_W-1:0] rev_count, rd_rev;
   logic             rd_valid, rd_ready, overflow;
   logic [$clog2(DEPTH):0] fifo_level;

   always #5 clk = ~clk;

   laser_beacon_tracker #(
      .POS_W(POS_W), .REV_W(REV_W), .DEPTH(DEPTH), .SIGNAL_ACTIVE_LOW(SAL), .FILTER_LEN(4)
   ) dut (
      .clk(clk), .reset(reset),
      .Laser_signal(Laser_signal), .Laser_sync(Laser_sync),
      .Laser_cod_A(Laser_cod_A), .Laser_cod_B(Laser_cod_B),
      .position(position), .rev_count(rev_count), .rev_period(rev_period),
      .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_start(rd_start), .rd_end(rd_end), .rd_rev(rd_rev),
      .fifo_level(fifo_level), .overflow(overflow)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [POS_W-1:0] s;
      logic [POS_W-1:0] e;
      logic [REV_W-1:0] r;
   } rec_t;

   rec_t             q[$];
   rec_t             rec;
   logic [POS_W-1:0] m_pos, m_period, m_spos;
   logic [REV_W-1:0] m_rev, m_srev;
   bit               m_open, m_ovf, m_ready;
   logic [3:0]       hist [3];   // pin samples taken 1, 2 and 3 edges ago
   logic [3:0]       cur, prv;
   bit               sr, on_c, on_p, pop, push;
   int               d;

   // Quadrature phase along the forward sequence 00 -> 10 -> 11 -> 01 (A,B).
   function automatic int phase_of(input logic a, input logic b);
      case ({a, b})
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_pos = '0; m_period = '0; m_rev = '0; m_spos = '0; m_srev = '0;
         m_open = 0; m_ovf = 0; q.delete();
         for (int i = 0; i < 3; i++) hist[i] = IDLE_PINS;
         m_ready = 1;
      end else begin
         cur  = hist[1];
         prv  = hist[2];
         sr   = cur[2] && !prv[2];
         on_c = (cur[3] == !SAL);
         on_p = (prv[3] == !SAL);
         d    = (phase_of(cur[1], cur[0]) - phase_of(prv[1], prv[0]) + 4) % 4;
         pop  = (q.size() != 0) && rd_ready;
         push = 0;
         if (m_open) begin
            if (sr) m_open = 0;
            else if (!on_c && on_p) begin
               rec = '{s: m_spos, e: m_pos, r: m_srev};
               push = 1;
               m_open = 0;
            end
         end else if (on_c && !on_p) begin
            m_open = 1;
            m_spos = sr ? '0 : m_pos;
            m_srev = sr ? m_rev + 1'b1 : m_rev;
         end
         if (pop) void'(q.pop_front());
         if (push) begin
            if (q.size() < DEPTH) q.push_back(rec);
            else m_ovf = 1;
         end
         if (sr) begin
            m_period = m_pos;
            m_pos    = '0;
            m_rev    = m_rev + 1'b1;
         end else if (d == 1) m_pos = m_pos + 1'b1;
         else if (d == 3)     m_pos = m_pos - 1'b1;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = reset ? IDLE_PINS : {Laser_signal, Laser_sync, Laser_cod_A, Laser_cod_B};
   end

   always @(negedge clk) begin
      if (m_ready) begin
         check("position", position, m_pos);
         check("rev_count", rev_count, m_rev);
         check("rev_period", rev_period, m_period);
         check("rd_valid", rd_valid, q.size() != 0);
         check("fifo_level", fifo_level, q.size());
         check("overflow", overflow, m_ovf);
         if (q.size() != 0) begin
            check("rd_start", rd_start, q[0].s);
            check("rd_end", rd_end, q[0].e);
            check("rd_rev", rd_rev, q[0].r);
         end
      end
   end

   // ---------------- stimulus ----------------
   int ph = 0;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ab();
      Laser_cod_A = (ph == 1 || ph == 2);
      Laser_cod_B = (ph == 2 || ph == 3);
   endtask

   task automatic enc_step(input bit fwd, input int gap);
      ph = fwd ? (ph + 1) % 4 : (ph + 3) % 4;
      set_ab();
      tick(gap);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(2);
   endtask

   task automatic pulse_sync();
      Laser_sync = 1'b1;
      tick(4);
      Laser_sync = 1'b0;
      tick(4);
   endtask

   initial begin
      reset = 1'b1; Laser_signal = 1'b1; Laser_sync = 1'b0; rd_ready = 1'b0;
      set_ab();
      tick(3);
      reset = 1'b0;
      tick(2);
      check("reset_position", position, 0);
      check("reset_level", fifo_level, 0);
      check("reset_valid", rd_valid, 0);
      check("reset_overflow", overflow, 0);

      // Count up/down.
      repeat (40) enc_step(1, 8);
      repeat (12) enc_step(0, 8);
      tick(4);
      check("count_28", position, 28);

      do_reset();
      enc_step(0, 8);
      check("wrap_ffff", position, 16'hFFFF);
      enc_step(1, 8);
      do_reset();

      // Sync, then a count edge coincident with sync.
      repeat (500) enc_step(1, 4);
      check("pos_500", position, 500);
      pulse_sync();
      check("period_500", rev_period, 500);
      check("sync_pos_0", position, 0);
      check("sync_rev_1", rev_count, 1);
      Laser_sync = 1'b1;
      enc_step(1, 4);
      Laser_sync = 1'b0;
      tick(4);
      check("coincident_pos_0", position, 0);
      check("coincident_rev_2", rev_count, 2);

      // Beacon capture in rev 2.
      repeat (100) enc_step(1, 4);
      Laser_signal = 1'b0;
      tick(4);
      repeat (30) enc_step(1, 4);
      Laser_signal = 1'b1;
      tick(4);
      check("cap_valid", rd_valid, 1);
      check("cap_level", fifo_level, 1);
      check("cap_start", rd_start, 100);
      check("cap_end", rd_end, 130);
      check("cap_rev", rd_rev, 2);
      rd_ready = 1'b1;
      tick(1);
      rd_ready = 1'b0;
      tick(1);
      check("pop_empty", rd_valid, 0);

      // Straddle across sync: discarded.
      repeat (770) enc_step(1, 4);
      Laser_signal = 1'b0;
      tick(4);
      pulse_sync();
      repeat (20) enc_step(1, 4);
      Laser_signal = 1'b1;
      tick(4);
      check("straddle_level", fifo_level, 0);
      check("straddle_pos", position, 20);

      // Overflow: 9 beacons into an 8-deep FIFO.
      repeat (9) begin
         enc_step(1, 4);
         Laser_signal = 1'b0;
         tick(4);
         enc_step(1, 4);
         Laser_signal = 1'b1;
         tick(4);
      end
      check("ovf_level", fifo_level, 8);
      check("ovf_flag", overflow, 1);
      check("ovf_head_start", rd_start, 21);
      check("ovf_head_end", rd_end, 22);
      check("ovf_head_rev", rd_rev, 3);
      enc_step(1, 4);
      Laser_signal = 1'b0;
      tick(4);
      enc_step(1, 4);
      Laser_signal = 1'b1;
      tick(2);
      rd_ready = 1'b1;
      tick(1);
      rd_ready = 1'b0;
      tick(3);
      check("full_pushpop_level", fifo_level, 8);
      check("full_pushpop_head", rd_start, 23);

      // Reset in the middle of a pulse.
      Laser_signal = 1'b0;
      tick(5);
      do_reset();
      check("midreset_level", fifo_level, 0);
      check("midreset_overflow", overflow, 0);
      Laser_signal = 1'b1;
      tick(4);

      // Randomized pin activity, including illegal double encoder steps and rare resets.
      repeat (4000) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 30) begin
            ph = ($urandom_range(0, 1) != 0) ? (ph + 1) % 4 : (ph + 3) % 4;
            set_ab();
         end else if (r < 32) begin
            ph = (ph + 2) % 4;
            set_ab();
         end
         if ($urandom_range(0, 5) == 0)  Laser_signal = ~Laser_signal;
         if ($urandom_range(0, 39) == 0) Laser_sync = ~Laser_sync;
         rd_ready = ($urandom_range(0, 3) == 0);
         reset    = ($urandom_range(0, 499) == 0);
         tick(1);
      end
      reset = 1'b0;
      rd_ready = 1'b0;
      tick(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
